// File: rtl/gol_pkg.sv
// Shared definitions for the game_of_life input path: key FSM encoding and default timing.
package gol_pkg;

   typedef enum logic [1:0] {
      KC_IDLE,
      KC_HELD_DELAY,
      KC_HELD_REPEAT
   } kc_state_e;

   localparam int unsigned KC_N_KEYS          = 4;
   localparam int unsigned KC_DEBOUNCE_CYCLES = 250000;
   localparam int unsigned KC_REPEAT_DELAY    = 12500000;
   localparam int unsigned KC_REPEAT_PERIOD   = 2500000;
   localparam int unsigned KC_CNT_W           = 24;

endpackage

// File: rtl/key_channel.sv
// One pushbutton: 2-flop synchroniser, debounce counter, hold/auto-repeat FSM.
module key_channel
   import gol_pkg::*;
#(
   parameter bit          KEY_ACTIVE_LOW  = 1'b1,
   parameter int unsigned DEBOUNCE_CYCLES = KC_DEBOUNCE_CYCLES,
   parameter int unsigned REPEAT_DELAY    = KC_REPEAT_DELAY,
   parameter int unsigned REPEAT_PERIOD   = KC_REPEAT_PERIOD,
   parameter int unsigned CNT_W           = KC_CNT_W
) (
   input  logic clk,
   input  logic reset,
   input  logic raw,
   output logic level,
   output logic press_pulse,
   output logic release_pulse,
   output logic strobe_pulse
);

   localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] RD_LAST  = CNT_W'(REPEAT_DELAY - 1);
   localparam logic [CNT_W-1:0] RP_LAST  = CNT_W'(REPEAT_PERIOD - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   logic             pressed_raw;
   logic             sync1;
   logic             sync2;
   logic [CNT_W-1:0] db_cnt;
   logic [CNT_W-1:0] rpt_cnt;
   logic             accept;
   kc_state_e        state;

   assign pressed_raw = KEY_ACTIVE_LOW ? ~raw : raw;
   // sync2 has differed from level for DEBOUNCE_CYCLES consecutive cycles
   assign accept      = (sync2 != level) && (db_cnt == DB_LAST);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync1         <= 1'b0;
         sync2         <= 1'b0;
         db_cnt        <= '0;
         rpt_cnt       <= '0;
         level         <= 1'b0;
         press_pulse   <= 1'b0;
         release_pulse <= 1'b0;
         strobe_pulse  <= 1'b0;
         state         <= KC_IDLE;
      end else begin
         sync1         <= pressed_raw;
         sync2         <= sync1;
         press_pulse   <= 1'b0;
         release_pulse <= 1'b0;
         strobe_pulse  <= 1'b0;

         if ((sync2 == level) || accept) begin
            db_cnt <= '0;
         end else begin
            db_cnt <= db_cnt + CNT_ONE;
         end

         if (accept) begin
            level <= sync2;
         end

         // An accepted release always wins over a coinciding repeat terminal count.
         case (state)
            KC_IDLE: begin
               if (accept && sync2) begin
                  press_pulse  <= 1'b1;
                  strobe_pulse <= 1'b1;
                  rpt_cnt      <= '0;
                  state        <= KC_HELD_DELAY;
               end
            end
            KC_HELD_DELAY: begin
               if (accept) begin
                  release_pulse <= 1'b1;
                  rpt_cnt       <= '0;
                  state         <= KC_IDLE;
               end else if (rpt_cnt == RD_LAST) begin
                  strobe_pulse <= 1'b1;
                  rpt_cnt      <= '0;
                  state        <= KC_HELD_REPEAT;
               end else begin
                  rpt_cnt <= rpt_cnt + CNT_ONE;
               end
            end
            KC_HELD_REPEAT: begin
               if (accept) begin
                  release_pulse <= 1'b1;
                  rpt_cnt       <= '0;
                  state         <= KC_IDLE;
               end else if (rpt_cnt == RP_LAST) begin
                  strobe_pulse <= 1'b1;
                  rpt_cnt      <= '0;
               end else begin
                  rpt_cnt <= rpt_cnt + CNT_ONE;
               end
            end
            default: begin
               rpt_cnt <= '0;
               state   <= KC_IDLE;
            end
         endcase
      end
   end

endmodule

// File: rtl/key_conditioner.sv
// Conditions N_KEYS raw pushbuttons into clean levels and press/release/repeat strobes.
module key_conditioner
   import gol_pkg::*;
#(
   parameter int unsigned N_KEYS          = KC_N_KEYS,
   parameter bit          KEY_ACTIVE_LOW  = 1'b1,
   parameter int unsigned DEBOUNCE_CYCLES = KC_DEBOUNCE_CYCLES,
   parameter int unsigned REPEAT_DELAY    = KC_REPEAT_DELAY,
   parameter int unsigned REPEAT_PERIOD   = KC_REPEAT_PERIOD,
   parameter int unsigned CNT_W           = KC_CNT_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [N_KEYS-1:0] key_raw,
   output logic [N_KEYS-1:0] key_level,
   output logic [N_KEYS-1:0] key_press,
   output logic [N_KEYS-1:0] key_release,
   output logic [N_KEYS-1:0] key_strobe
);

   for (genvar i = 0; i < N_KEYS; i++) begin : g_ch
      key_channel #(
         .KEY_ACTIVE_LOW  (KEY_ACTIVE_LOW),
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .REPEAT_DELAY    (REPEAT_DELAY),
         .REPEAT_PERIOD   (REPEAT_PERIOD),
         .CNT_W           (CNT_W)
      ) u_ch (
         .clk           (clk),
         .reset         (reset),
         .raw           (key_raw[i]),
         .level         (key_level[i]),
         .press_pulse   (key_press[i]),
         .release_pulse (key_release[i]),
         .strobe_pulse  (key_strobe[i])
      );
   end

endmodule

// File: tb/tb_key_conditioner.sv
// Scoreboard bench: timing-rule reference model feeds an expected queue, a negedge monitor compares.
module tb_key_conditioner;

   localparam int DEB = 8;
   localparam int RD  = 20;
   localparam int RP  = 5;

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] key_raw;
   logic [3:0] key_level, key_press, key_release, key_strobe;

   int n_checks = 0;
   int n_fail   = 0;
   int mon_cyc  = 0;
   int press2_cnt = 0;
   int strobe2_cnt = 0;
   int pulse_cnt = 0;

   logic [15:0] exp_q[$];

   key_conditioner #(
      .N_KEYS          (4),
      .KEY_ACTIVE_LOW  (1'b1),
      .DEBOUNCE_CYCLES (DEB),
      .REPEAT_DELAY    (RD),
      .REPEAT_PERIOD   (RP),
      .CNT_W           (24)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .key_raw     (key_raw),
      .key_level   (key_level),
      .key_press   (key_press),
      .key_release (key_release),
      .key_strobe  (key_strobe)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s (cycle %0d): got %h expected %h", name, mon_cyc, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   // Reference model: a press/release is accepted once the 2-cycle-delayed pin has
   // disagreed with the accepted level for DEB edges in a row; repeats follow from
   // elapsed time since the press.
   initial begin
      logic [3:0] s1, s2, lvl, ep, er, es;
      int run[4];
      int pt[4];
      int cyc;
      logic d;
      int e;
      s1 = '0; s2 = '0; lvl = '0; cyc = 0;
      for (int k = 0; k < 4; k++) begin run[k] = 0; pt[k] = 0; end
      forever begin
         @(posedge clk);
         ep = '0; er = '0; es = '0;
         if (!reset) begin
            s1 = '0; s2 = '0; lvl = '0;
            for (int k = 0; k < 4; k++) run[k] = 0;
         end else begin
            for (int k = 0; k < 4; k++) begin
               d = s2[k];
               s2[k] = s1[k];
               s1[k] = ~key_raw[k];
               if (d != lvl[k]) run[k]++;
               else run[k] = 0;
               if (run[k] == DEB) begin
                  run[k] = 0;
                  lvl[k] = d;
                  if (d) begin
                     ep[k] = 1'b1; es[k] = 1'b1; pt[k] = cyc;
                  end else begin
                     er[k] = 1'b1;
                  end
               end else if (lvl[k]) begin
                  e = cyc - pt[k];
                  if (e == RD || (e > RD && (e - RD) % RP == 0)) es[k] = 1'b1;
               end
            end
            cyc++;
         end
         exp_q.push_back({lvl, ep, er, es});
      end
   end

   // Monitor: every cycle the DUT presents a full output vector.
   initial begin
      logic [15:0] ev;
      forever begin
         @(negedge clk);
         mon_cyc++;
         if (exp_q.size() > 0) begin
            ev = exp_q.pop_front();
            if (!reset) ev = '0;
            chk("outputs", {key_level, key_press, key_release, key_strobe}, ev);
            if (reset) begin
               if (key_press[2])  press2_cnt++;
               if (key_strobe[2]) strobe2_cnt++;
               if (|{key_press, key_release, key_strobe}) pulse_cnt++;
            end
         end
      end
   end

   initial begin
      logic [3:0] want, raw_v;
      int since[4];
      int p0;
      reset   = 1'b0;
      key_raw = 4'hF;
      tick(3);
      chk("reset_outputs", {key_level, key_press, key_release, key_strobe}, 16'h0);
      reset = 1'b1;
      tick(5);

      // clean press on key 0
      key_raw[0] = 1'b0;
      tick(9);
      chk("press0_early", {15'h0, key_press[0]}, 16'h0);
      tick(1);
      chk("press0", {14'h0, key_press[0], key_strobe[0]}, 16'h3);
      chk("level0_rise", {15'h0, key_level[0]}, 16'h1);
      tick(1);
      chk("press0_once", {15'h0, key_press[0]}, 16'h0);
      key_raw[0] = 1'b1;
      tick(15);

      // bounce on key 1, then a steady press
      key_raw[1] = 1'b0; tick(5);
      key_raw[1] = 1'b1; tick(1);
      key_raw[1] = 1'b0; tick(5);
      key_raw[1] = 1'b1; tick(15);
      chk("level1_bounce", {15'h0, key_level[1]}, 16'h0);
      key_raw[1] = 1'b0;
      tick(9);
      chk("press1_early", {15'h0, key_press[1]}, 16'h0);
      tick(1);
      chk("press1", {15'h0, key_press[1]}, 16'h1);
      key_raw[1] = 1'b1;
      tick(15);

      // auto-repeat on key 2; release lands on a repeat terminal count (+70)
      key_raw[2] = 1'b0;
      tick(10);
      chk("press2", {15'h0, key_press[2]}, 16'h1);
      tick(60);
      key_raw[2] = 1'b1;
      tick(15);
      chk("press2_count", 16'(press2_cnt), 16'd1);
      chk("strobe2_count", 16'(strobe2_cnt), 16'd11);
      chk("level2_fall", {15'h0, key_level[2]}, 16'h0);

      // concurrent press on keys 0 and 3, then reset during the hold
      key_raw = 4'b0110;
      tick(10);
      chk("press_concurrent", {12'h0, key_press}, 16'h9);
      tick(8);
      key_raw = 4'b0000;
      reset   = 1'b0;
      #1;
      chk("async_reset", {key_level, key_press, key_release, key_strobe}, 16'h0);
      tick(3);
      key_raw = 4'hF;
      reset   = 1'b1;
      p0 = pulse_cnt;
      tick(50);
      chk("quiet_after_reset", 16'(pulse_cnt - p0), 16'h0);

      // randomized presses with bounce, one reset in the middle
      want = 4'hF;
      for (int k = 0; k < 4; k++) since[k] = 1000;
      for (int c = 0; c < 3000; c++) begin
         for (int k = 0; k < 4; k++) begin
            if ($urandom_range(0, 79) == 0) begin
               want[k] = ~want[k];
               since[k] = 0;
            end else if (since[k] < 1000) begin
               since[k]++;
            end
            raw_v[k] = (since[k] < 12 && $urandom_range(0, 3) == 0) ? ~want[k] : want[k];
         end
         key_raw = raw_v;
         if (c == 1700) reset = 1'b0;
         if (c == 1705) reset = 1'b1;
         tick(1);
      end
      key_raw = 4'hF;
      tick(4);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
